// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and types for the UART receive path and its byte FIFO.
package uart_rx_fifo_pkg;

  // UART byte width; uart_rx dout and the FIFO data path agree on this.
  localparam int UART_DATA_W = 8;

  // Default FIFO address width (depth = 2**UART_FIFO_ADDR_W).
  localparam int UART_FIFO_ADDR_W = 4;

  // Oversampling divisor: 16x sampling at 19200 baud from a 50 MHz clock.
  localparam int UART_OVERSAMPLE_DIV = 163;

  // Effective FIFO operation for one edge, after qualifying the strobes
  // against full/empty: {write happens, read happens}.
  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/uart_rx_fifo_ctrl.sv
// Pointer, occupancy and overflow bookkeeping for the receive FIFO.
// The register file itself lives in the top level; this block only says
// where to write, where to read, and whether the write is accepted.
module fifo_ctrl
  import uart_rx_fifo_pkg::*;
#(
  parameter int ADDR_W = UART_FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic              clr_overflow,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] r_addr,
  output logic              wr_en,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

  logic [ADDR_W-1:0] r_wPtr;
  logic [ADDR_W-1:0] r_rPtr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_overflow;

  logic              w_wrEn;
  logic              w_rdEn;
  logic              w_ovfSet;
  fifo_op_e          w_op;
  logic [ADDR_W:0]   w_countNext;
  logic              w_fullNext;
  logic              w_emptyNext;

  // A write is accepted unless full; when full, a simultaneous read frees
  // the slot the write lands in (w_ptr == r_ptr), so it is still accepted.
  assign w_wrEn   = wr & (~r_full | rd);
  assign w_rdEn   = rd & ~r_empty;
  assign w_ovfSet = wr & ~w_wrEn;
  assign w_op     = fifo_op_e'({w_wrEn, w_rdEn});

  // Next occupancy and flags; a combined read+write leaves them untouched.
  always_comb begin
    w_countNext = r_count;
    w_fullNext  = r_full;
    w_emptyNext = r_empty;
    case (w_op)
      OP_WRITE: begin
        w_countNext = r_count + (ADDR_W+1)'(1);
        w_emptyNext = 1'b0;
        w_fullNext  = (w_countNext == DEPTH);
      end
      OP_READ: begin
        w_countNext = r_count - (ADDR_W+1)'(1);
        w_fullNext  = 1'b0;
        w_emptyNext = (r_count == (ADDR_W+1)'(1));
      end
      default: begin
        w_countNext = r_count;
      end
    endcase
  end

  // Pointers wrap naturally at 2**ADDR_W; flags are registered, not decoded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wPtr  <= '0;
      r_rPtr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_wrEn) r_wPtr <= r_wPtr + ADDR_W'(1);
      if (w_rdEn) r_rPtr <= r_rPtr + ADDR_W'(1);
      r_count <= w_countNext;
      r_full  <= w_fullNext;
      r_empty <= w_emptyNext;
    end
  end

  // Sticky overflow: a dropped write wins over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_ovfSet) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign w_addr   = r_wPtr;
  assign r_addr   = r_rPtr;
  assign wr_en    = w_wrEn;
  assign full     = r_full;
  assign empty    = r_empty;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte buffer behind uart_rx: captures dout on each
// rx_done_tick and holds it until the consumer pops it.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = UART_FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              rd,
  output logic [DATA_W-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_overflow
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [ADDR_W-1:0] w_wAddr;
  logic [ADDR_W-1:0] w_rAddr;
  logic              w_wrEn;

  fifo_ctrl #(
    .ADDR_W(ADDR_W)
  ) u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .rd           (rd),
    .clr_overflow (clr_overflow),
    .w_addr       (w_wAddr),
    .r_addr       (w_rAddr),
    .wr_en        (w_wrEn),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow)
  );

  // Storage is deliberately not reset; empty/count say what is valid.
  always_ff @(posedge clk) begin
    if (w_wrEn) r_mem[w_wAddr] <= w_data;
  end

  assign r_data = r_mem[w_rAddr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based model.
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr;
  logic [DW-1:0] w_data;
  logic          rd;
  logic          clr_overflow;
  logic [DW-1:0] r_data;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overflow;

  logic [DW-1:0] modelQ[$];
  logic          modelOvf;
  int            nCompared   = 0;
  int            nMismatched = 0;

  uart_rx_fifo #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .w_data       (w_data),
    .rd           (rd),
    .r_data       (r_data),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  // 50 MHz clock.
  always #10 clk = ~clk;

  // Queue semantics: pop the oldest if anything is stored, push if there is
  // room (or room was just made by the pop); a refused push sets overflow.
  task automatic modelUpdate(input logic iWr, input logic [DW-1:0] iData,
                             input logic iRd, input logic iClr);
    bit doPop;
    bit doPush;
    doPop  = iRd && (modelQ.size() > 0);
    doPush = iWr && ((modelQ.size() < DEPTH) || doPop);
    if (doPop) void'(modelQ.pop_front());
    if (doPush) modelQ.push_back(iData);
    if (iWr && !doPush) modelOvf = 1'b1;
    else if (iClr) modelOvf = 1'b0;
  endtask

  // Drive one cycle of strobes, let the edge happen, then release them.
  task automatic step(input logic iWr, input logic [DW-1:0] iData,
                      input logic iRd, input logic iClr);
    wr = iWr; w_data = iData; rd = iRd; clr_overflow = iClr;
    @(posedge clk);
    modelUpdate(iWr, iData, iRd, iClr);
    #1;
    wr = 1'b0; rd = 1'b0; clr_overflow = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr = 1'b0; rd = 1'b0; clr_overflow = 1'b0; w_data = '0;
    modelQ.delete(); modelOvf = 1'b0;
    repeat (2) @(posedge clk);
    #5 reset = 1'b0;
    @(posedge clk); #1;
    nCompared++;
    if (empty !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_empty actual=%b required=1", empty); end
    nCompared++;
    if (full !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_full actual=%b required=0", full); end
    nCompared++;
    if (count !== 5'd0) begin nMismatched++; $display("[TB] FAIL reset_count actual=%0d required=0", count); end
    nCompared++;
    if (overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_overflow actual=%b required=0", overflow); end
  endtask

  task automatic test_single_write();
    step(1'b1, 8'hD1, 1'b0, 1'b0);
    nCompared++;
    if (empty !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_empty actual=%b required=0", empty); end
    nCompared++;
    if (r_data !== 8'hD1) begin nMismatched++; $display("[TB] FAIL single_rdata actual=%h required=d1", r_data); end
    nCompared++;
    if (count !== 5'd1) begin nMismatched++; $display("[TB] FAIL single_count actual=%0d required=1", count); end
    nCompared++;
    if (overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_overflow actual=%b required=0", overflow); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    nCompared++;
    if (empty !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_drain_empty actual=%b required=1", empty); end
  endtask

  // Two full fill/drain passes; the second one runs the pointers across the wrap.
  task automatic test_fill_drain();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      nCompared++;
      if (full !== 1'b1) begin nMismatched++; $display("[TB] FAIL fill_full pass=%0d actual=%b required=1", pass, full); end
      nCompared++;
      if (count !== 5'd16) begin nMismatched++; $display("[TB] FAIL fill_count pass=%0d actual=%0d required=16", pass, count); end
      for (int i = 0; i < DEPTH; i++) begin
        nCompared++;
        if (r_data !== 8'(i)) begin nMismatched++; $display("[TB] FAIL drain_data pass=%0d idx=%0d actual=%h required=%h", pass, i, r_data, 8'(i)); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      nCompared++;
      if (empty !== 1'b1 || count !== 5'd0) begin nMismatched++; $display("[TB] FAIL drain_state pass=%0d actual empty=%b count=%0d required empty=1 count=0", pass, empty, count); end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    nCompared++;
    if (overflow !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf_set actual=%b required=1", overflow); end
    nCompared++;
    if (count !== 5'd16) begin nMismatched++; $display("[TB] FAIL ovf_count actual=%0d required=16", count); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    nCompared++;
    if (overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL ovf_clear actual=%b required=0", overflow); end
    step(1'b1, 8'hBB, 1'b0, 1'b1);
    nCompared++;
    if (overflow !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf_set_and_clear actual=%b required=1", overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      nCompared++;
      if (r_data !== modelQ[0]) begin nMismatched++; $display("[TB] FAIL ovf_readback idx=%0d actual=%h required=%h", i, r_data, modelQ[0]); end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    nCompared++;
    if (overflow !== modelOvf) begin nMismatched++; $display("[TB] FAIL ovf_final actual=%b required=%b", overflow, modelOvf); end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] lastRead;
    // At empty: the write alone takes effect.
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    nCompared++;
    if (count !== 5'd1 || r_data !== 8'h5A) begin nMismatched++; $display("[TB] FAIL simul_empty actual count=%0d data=%h required count=1 data=5a", count, r_data); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    // At full: pop plus push, no overflow, new byte comes out last.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b1, 1'b0);
    nCompared++;
    if (count !== 5'd16 || full !== 1'b1) begin nMismatched++; $display("[TB] FAIL simul_full_count actual=%0d full=%b required=16 full=1", count, full); end
    nCompared++;
    if (overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL simul_full_overflow actual=%b required=0", overflow); end
    lastRead = '0;
    for (int i = 0; i < DEPTH; i++) begin
      nCompared++;
      if (r_data !== modelQ[0]) begin nMismatched++; $display("[TB] FAIL simul_full_data idx=%0d actual=%h required=%h", i, r_data, modelQ[0]); end
      lastRead = r_data;
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    nCompared++;
    if (lastRead !== 8'hC3) begin nMismatched++; $display("[TB] FAIL simul_full_last actual=%h required=c3", lastRead); end
    // At half full: occupancy unchanged.
    for (int i = 0; i < DEPTH/2; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b1, 1'b0);
    nCompared++;
    if (count !== 5'd8 || empty !== 1'b0 || full !== 1'b0) begin nMismatched++; $display("[TB] FAIL simul_half actual count=%0d empty=%b full=%b required count=8 empty=0 full=0", count, empty, full); end
    nCompared++;
    if (r_data !== modelQ[0]) begin nMismatched++; $display("[TB] FAIL simul_half_data actual=%h required=%h", r_data, modelQ[0]); end
    for (int i = 0; i < DEPTH/2; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_read_empty();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    nCompared++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL read_empty actual count=%0d empty=%b full=%b ovf=%b required count=0 empty=1 full=0 ovf=0", count, empty, full, overflow);
    end
  endtask

  // Build 7 entries with overflow set, then reset asynchronously mid-cycle.
  task automatic test_reset_midop();
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    nCompared++;
    if (count !== 5'd7 || overflow !== 1'b1) begin nMismatched++; $display("[TB] FAIL pre_reset actual count=%0d ovf=%b required count=7 ovf=1", count, overflow); end
    wr = 1'b1; w_data = 8'h77;
    #4 reset = 1'b1;
    #1;
    modelQ.delete(); modelOvf = 1'b0;
    nCompared++;
    if (empty !== 1'b1 || count !== 5'd0 || overflow !== 1'b0 || full !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL async_reset actual empty=%b count=%0d ovf=%b full=%b required empty=1 count=0 ovf=0 full=0", empty, count, overflow, full);
    end
    @(posedge clk); #1;
    wr = 1'b0;
    reset = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    nCompared++;
    if (empty !== 1'b1 || count !== 5'd0) begin nMismatched++; $display("[TB] FAIL reset_wr_lost actual empty=%b count=%0d required empty=1 count=0", empty, count); end
  endtask

  task automatic test_random();
    logic          iWr;
    logic          iRd;
    logic          iClr;
    logic [DW-1:0] iData;
    for (int n = 0; n < 400; n++) begin
      iWr   = ($urandom_range(0, 99) < 55);
      iRd   = ($urandom_range(0, 99) < 45);
      iClr  = ($urandom_range(0, 99) < 8);
      iData = 8'($urandom);
      if (modelQ.size() > 0) begin
        nCompared++;
        if (r_data !== modelQ[0]) begin nMismatched++; $display("[TB] FAIL rand_data n=%0d actual=%h required=%h", n, r_data, modelQ[0]); end
      end
      step(iWr, iData, iRd, iClr);
      nCompared++;
      if (count !== 5'(modelQ.size()) || empty !== (modelQ.size() == 0) ||
          full !== (modelQ.size() == DEPTH) || overflow !== modelOvf) begin
        nMismatched++;
        $display("[TB] FAIL rand_state n=%0d actual count=%0d empty=%b full=%b ovf=%b required count=%0d empty=%b full=%b ovf=%b",
                 n, count, empty, full, overflow, modelQ.size(), (modelQ.size() == 0), (modelQ.size() == DEPTH), modelOvf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill_drain();
    test_overflow();
    test_simultaneous();
    test_read_empty();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
